// File: rtl/vga_raster_timing.sv
// rtl/vga_raster_timing.sv - VGA raster timing: x/y counters, registered hsync/vsync/blank, sticky vblank irq.
// Optional VGA_LINE_IRQ_EN adds irq_line and a programmable line-compare interrupt at start of hblank.
module vga_raster_timing #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
`ifdef VGA_LINE_IRQ_EN
  input  logic [9:0]  irq_line,
`endif
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        interrupt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_mode
    $error("vga_raster_timing: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = (HSYNC_POL != 0);
  localparam logic        VS_ON    = (VSYNC_POL != 0);

  logic [10:0] nx;
  logic [9:0]  ny;
  logic        hs_act;
  logic        vs_act;
  logic        blank_nxt;
  logic        set_evt;

  always_comb begin
    nx = x + 11'd1;
    ny = y;
    if (x == H_LAST) begin
      nx = 11'd0;
      ny = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  // Decoding the next-state counters lets the registered syncs line up with x/y.
  always_comb begin
    hs_act    = (nx >= HS_START) && (nx < HS_END);
    vs_act    = (ny >= VS_START) && (ny < VS_END);
    blank_nxt = (nx >= H_ACT) || (ny >= V_ACT);
    set_evt   = (nx == 11'd0) && (ny == V_ACT);
`ifdef VGA_LINE_IRQ_EN
    if ((nx == H_ACT) && (ny == irq_line) && (irq_line <= V_LAST)) begin
      set_evt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= 11'd0;
      y         <= 10'd0;
      hsync     <= ~HS_ON;
      vsync     <= ~VS_ON;
      blank     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      x     <= nx;
      y     <= ny;
      hsync <= hs_act ? HS_ON : ~HS_ON;
      vsync <= vs_act ? VS_ON : ~VS_ON;
      blank <= blank_nxt;
      // A set event on the same edge as cli keeps the request pending.
      if (set_evt) begin
        interrupt <= 1'b1;
      end else if (cli) begin
        interrupt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_raster_timing.sv
// tb/tb_vga_raster_timing.sv - scoreboard bench for vga_raster_timing in a reduced 64x40 raster mode.
module tb_vga_raster_timing;

  // Reduced mode: H 40+4+8+12 = 64, V 30+2+3+5 = 40, frame = 2560 clks.
  localparam int HA = 40, HF = 4, HS = 8, HB = 12;
  localparam int VA = 30, VF = 2, VS = 3, VB = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cli = 1'b0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        hsync, vsync, blank, interrupt;
`ifdef VGA_LINE_IRQ_EN
  logic [9:0]  irq_line = 10'd5;
  localparam logic LI = 1'b1;
`else
  localparam logic LI = 1'b0;
`endif

  vga_raster_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cli(cli),
`ifdef VGA_LINE_IRQ_EN
    .irq_line(irq_line),
`endif
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .blank(blank),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hs, vs, bl, irq;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int c, input int ex, input int ey,
                      input logic hs, input logic vs, input logic bl, input logic irq);
    exp_t e;
    e.cyc = c; e.x = 11'(ex); e.y = 10'(ey);
    e.hs = hs; e.vs = vs; e.bl = bl; e.irq = irq;
    sb.push_back(e);
  endtask

  // Monitor: compares the head entry when the raster reaches its cycle.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      if (cyc == sb[0].cyc) begin
        compared++;
        if ({x, y, hsync, vsync, blank, interrupt} !==
            {sb[0].x, sb[0].y, sb[0].hs, sb[0].vs, sb[0].bl, sb[0].irq}) begin
          mismatched++;
          $display("FAIL cyc%0d: got x=%0d y=%0d hs=%b vs=%b bl=%b irq=%b, want x=%0d y=%0d hs=%b vs=%b bl=%b irq=%b",
                   cyc, x, y, hsync, vsync, blank, interrupt,
                   sb[0].x, sb[0].y, sb[0].hs, sb[0].vs, sb[0].bl, sb[0].irq);
        end
        void'(sb.pop_front());
      end else if (cyc > sb[0].cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missed_cyc%0d: raster at cyc %0d, want check at cyc %0d", sb[0].cyc, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (cyc != n && guard < 10000);
    if (cyc != n) begin
      compared++;
      mismatched++;
      $display("FAIL wait_cyc: at cyc %0d, want cyc %0d", cyc, n);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d checks left, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    push(0,    0,  0, 1, 1, 0, 0);
    push(39,  39,  0, 1, 1, 0, 0);
    push(40,  40,  0, 1, 1, 1, 0);
    push(43,  43,  0, 1, 1, 1, 0);
    push(44,  44,  0, 0, 1, 1, 0);
    push(51,  51,  0, 0, 1, 1, 0);
    push(52,  52,  0, 1, 1, 1, 0);
    push(63,  63,  0, 1, 1, 1, 0);
    push(64,   0,  1, 1, 1, 0, 0);
`ifdef VGA_LINE_IRQ_EN
    push(359, 39,  5, 1, 1, 0, 0);
    push(360, 40,  5, 1, 1, 1, 1);
`endif
    push(1895, 39, 29, 1, 1, 0, LI);
    push(1920,  0, 30, 1, 1, 1, 1);
    push(1930, 10, 30, 1, 1, 1, 1);
    push(1931, 11, 30, 1, 1, 1, 0);
    push(1984,  0, 31, 1, 1, 1, 0);
    push(2047, 63, 31, 1, 1, 1, 0);
    push(2048,  0, 32, 1, 0, 1, 0);
    push(2239, 63, 34, 1, 0, 1, 0);
    push(2240,  0, 35, 1, 1, 1, 0);
    push(2559, 63, 39, 1, 1, 1, 0);
    push(2560,  0,  0, 1, 1, 0, 0);
    push(4470, 54, 29, 1, 1, 1, 0);
    push(4480,  0, 30, 1, 1, 1, 1);
    push(4481,  1, 30, 1, 1, 1, 1);
    push(4485,  5, 30, 1, 1, 1, 1);
    push(4718, 46, 33, 0, 0, 1, 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef VGA_LINE_IRQ_EN
    wait_cyc(400);
    irq_line = 10'd50;
`endif
    wait_cyc(1930);
    cli = 1'b1;
    wait_cyc(1931);
    cli = 1'b0;
    wait_cyc(4460);
    cli = 1'b1;
    wait_cyc(4480);
    cli = 1'b0;
    wait_cyc(4719);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();

    push(0,   0, 0, 1, 1, 0, 0);
    push(1,   1, 0, 1, 1, 0, 0);
    push(65,  1, 1, 1, 1, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, want completion");
    $fatal(1);
  end

endmodule

// File: doc/vga_raster_timing.md
Name: vga_raster_timing

Overview:
- Raster timing generator for the 1-bit VGA framebuffer peripheral on the TinyQV 64 MHz clock.
- Default mode is 1024x768 @ ~59 Hz, one pixel per clk.
- Produces:
  - the x/y beam position;
  - hsync, vsync and blank, all cycle-aligned with x/y;
  - a sticky vertical-blank interrupt that software clears.
- Sits directly upstream of the pixel/colour stage, which registers hsync/vsync/pixel for one further cycle before the PMOD.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clks)
- H_SYNC, 136, hsync pulse width (clks)
- H_BP, 160, horizontal back porch (clks)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active low)
- VSYNC_POL, 0, active level of vsync (0 = active low)

Ports:
- clk  in  1  system clock, 64 MHz
- rst_n  in  1  synchronous active-low reset
- cli  in  1  interrupt clear; level, sampled each clk
- x  out  11  current horizontal position, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- blank  out  1  1 when (x,y) lies outside the active area
- interrupt  out  1  sticky vblank interrupt request
- irq_line  in  10  line-compare value; present only with VGA_LINE_IRQ_EN

Behaviour:
- Reset: rst_n is synchronous active-low on clk. With rst_n low at a clk edge:
  - x = 0, y = 0;
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL;
  - blank = 0;
  - interrupt = 0.
- Mid-frame reset returns the block to this state on the next edge; no partial line is completed.
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP, default 1344;
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP, default 806.
  - H_TOTAL must be ≤ 2048 and V_TOTAL ≤ 1024; otherwise it is an elaboration error.
- Counters:
  - x increments by 1 every clk.
  - At x == H_TOTAL-1, x wraps to 0 and y increments.
  - At x == H_TOTAL-1 and y == V_TOTAL-1, both wrap to 0.
  - No stall input exists; the counters free-run.
- hsync, vsync and blank are registers computed from the next-state counter values, so they always describe the x/y presented in the same cycle. There is zero latency between x/y and the syncs, and the outputs are glitch-free.
- Decode, with (nx, ny) the next-state counter values:
  - hsync is active when H_ACTIVE+H_FP ≤ nx < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
  - vsync is active when V_ACTIVE+V_FP ≤ ny < V_ACTIVE+V_FP+V_SYNC (default 771..776), for whole lines including hblank.
  - blank = (nx ≥ H_ACTIVE) | (ny ≥ V_ACTIVE).
- Interrupt:
  - Set event: the cycle in which the counters become x == 0, y == V_ACTIVE (first vblank line).
  - interrupt is registered and goes high in that same cycle.
  - It stays high until a clk edge with cli = 1, then drops the following cycle.
  - If the set event and cli = 1 occur on the same edge, the set wins and interrupt stays 1.
  - cli with interrupt already 0 has no effect.
- All arithmetic is unsigned. Comparisons use 11-bit x and 10-bit y widths, with parameters truncated to those widths.

Optional Feature:
- Macro: VGA_LINE_IRQ_EN.
- With the macro defined:
  - Port irq_line[9:0] exists.
  - An additional set event occurs when the counters become x == H_ACTIVE (start of hblank) with y == irq_line.
  - It sets the same sticky interrupt bit, with the same cli and priority rules as the vblank event.
  - irq_line ≥ V_TOTAL never matches.
  - irq_line is sampled at the compare cycle only.
- Without the macro: no irq_line port, and only the vblank event sets interrupt.

Test Plan:
- Reset, then release rst_n → cycle 0:
  - x = 0, y = 0, blank = 0, hsync = 1, vsync = 1, interrupt = 0.
- Horizontal timing:
  - After 1023 clks, x = 1023 and blank = 0.
  - The next clk gives x = 1024 and blank = 1.
  - hsync = 0 exactly for x = 1048..1183.
  - At 1344 clks, x = 0, y = 1, blank = 0.
- Vertical timing:
  - At clk 768·1344 = 1032192: y = 768, x = 0, blank = 1, interrupt = 1.
  - vsync = 0 for y = 771..776 only.
  - At clk 1083264: x = 0, y = 0, blank = 0.
- Interrupt clear:
  - cli pulse for one clk while interrupt = 1 → interrupt = 0 next cycle.
  - cli held high across the set cycle at y = 768 → interrupt = 1.
- Reset mid-line at x = 500, y = 300 → next cycle x = 0, y = 0, interrupt = 0, syncs inactive.
- VGA_LINE_IRQ_EN build with irq_line = 100 → interrupt rises at x = 1024, y = 100.
- VGA_LINE_IRQ_EN build with irq_line = 900 → only the vblank event fires.
